// File: rtl/controle_jogo_pkg.sv
// Shared types and constants for the two-secret guessing game controller.
package controle_jogo_pkg;

   localparam int TENT_W = 4;

   typedef enum logic [2:0] {
      PROG_A   = 3'd0,
      PROG_B   = 3'd1,
      ADIV_A   = 3'd2,
      AVALIA_A = 3'd3,
      ADIV_B   = 3'd4,
      AVALIA_B = 3'd5,
      VITORIA  = 3'd6,
      DERROTA  = 3'd7
   } estado_t;

   localparam logic [1:0] COMP_MENOR = 2'b00;
   localparam logic [1:0] COMP_MAIOR = 2'b01;
   localparam logic [1:0] COMP_IGUAL = 2'b10;
   localparam logic [1:0] DICA_NULA  = 2'b11;

endpackage

// File: rtl/controle_jogo_contador_tentativas.sv
// Saturating attempt counter: counts confirmed guesses up to MAX, flags exhaustion.
module contador_tentativas
   import controle_jogo_pkg::*;
#(
   parameter int MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,
   input  logic              clr,
   output logic [TENT_W-1:0] cnt,
   output logic              esgotado
);

   logic [TENT_W-1:0] cnt_q;
   logic [TENT_W-1:0] cnt_d;

   // next count: clear wins, increment stops at the budget
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {TENT_W{1'b0}};
      end else if (inc && (cnt_q != TENT_W'(MAX))) begin
         cnt_d = cnt_q + TENT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {TENT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt      = cnt_q;
   assign esgotado = (cnt_q == TENT_W'(MAX));

endmodule

// File: rtl/controle_jogo.sv
// Game sequencer: programs secrets A/B, collects guesses, declares win/loss.
// Define CONTROLE_JOGO_ULTIMA_DICA_EN to register the last sampled comp on ultima_dica.
module controle_jogo
   import controle_jogo_pkg::*;
#(
   parameter int MAX_TENT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        sw_valor,
   input  logic              btn_confirma,
   input  logic [1:0]        comp,
   output logic [3:0]        senhaA,
   output logic [2:0]        senhaB,
   output logic [3:0]        tentativaA,
   output logic [2:0]        tentativaB,
   output logic              modoB,
   output logic [TENT_W-1:0] tentativas,
   output logic              vitoria,
   output logic              derrota,
   output logic [2:0]        fase,
   output logic [1:0]        ultima_dica
);

   estado_t    estado_q, estado_d;
   logic [3:0] senha_a_q, senha_a_d;
   logic [2:0] senha_b_q, senha_b_d;
   logic [3:0] tent_a_q, tent_a_d;
   logic [2:0] tent_b_q, tent_b_d;
   logic       modo_b_q, modo_b_d;
   logic       vitoria_q, vitoria_d;
   logic       derrota_q, derrota_d;
   logic       cnt_inc, cnt_clr, esgotado;

   contador_tentativas #(.MAX(MAX_TENT)) u_contador (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (cnt_inc),
      .clr      (cnt_clr),
      .cnt      (tentativas),
      .esgotado (esgotado)
   );

   // next-state and data-path decisions
   always_comb begin
      estado_d  = estado_q;
      senha_a_d = senha_a_q;
      senha_b_d = senha_b_q;
      tent_a_d  = tent_a_q;
      tent_b_d  = tent_b_q;
      cnt_inc   = 1'b0;
      cnt_clr   = 1'b0;
      case (estado_q)
         PROG_A: begin
            if (btn_confirma) begin
               senha_a_d = sw_valor;
               estado_d  = PROG_B;
            end else begin
               estado_d  = PROG_A;
            end
         end
         PROG_B: begin
            if (btn_confirma) begin
               senha_b_d = sw_valor[2:0];
               estado_d  = ADIV_A;
            end else begin
               estado_d  = PROG_B;
            end
         end
         ADIV_A: begin
            if (btn_confirma) begin
               tent_a_d = sw_valor;
               cnt_inc  = 1'b1;
               estado_d = AVALIA_A;
            end else begin
               estado_d = ADIV_A;
            end
         end
         // equality is checked before the budget so a hit on the last try still counts
         AVALIA_A: begin
            if (comp == COMP_IGUAL) begin
               estado_d = ADIV_B;
            end else if (esgotado) begin
               estado_d = DERROTA;
            end else begin
               estado_d = ADIV_A;
            end
         end
         ADIV_B: begin
            if (btn_confirma) begin
               tent_b_d = sw_valor[2:0];
               cnt_inc  = 1'b1;
               estado_d = AVALIA_B;
            end else begin
               estado_d = ADIV_B;
            end
         end
         AVALIA_B: begin
            if (comp == COMP_IGUAL) begin
               estado_d = VITORIA;
            end else if (esgotado) begin
               estado_d = DERROTA;
            end else begin
               estado_d = ADIV_B;
            end
         end
         VITORIA, DERROTA: begin
            if (btn_confirma) begin
               senha_a_d = 4'd0;
               senha_b_d = 3'd0;
               tent_a_d  = 4'd0;
               tent_b_d  = 3'd0;
               cnt_clr   = 1'b1;
               estado_d  = PROG_A;
            end else begin
               estado_d  = estado_q;
            end
         end
         default: begin
            estado_d = PROG_A;
         end
      endcase
   end

   // flag outputs are computed from the next state so they register with it
   always_comb begin
      modo_b_d  = modo_b_q;
      if (cnt_clr) begin
         modo_b_d = 1'b0;
      end else if ((estado_d == ADIV_B) || (estado_d == AVALIA_B)) begin
         modo_b_d = 1'b1;
      end else begin
         modo_b_d = modo_b_q;
      end
      vitoria_d = (estado_d == VITORIA);
      derrota_d = (estado_d == DERROTA);
   end

   // state and data registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q  <= PROG_A;
         senha_a_q <= 4'd0;
         senha_b_q <= 3'd0;
         tent_a_q  <= 4'd0;
         tent_b_q  <= 3'd0;
         modo_b_q  <= 1'b0;
         vitoria_q <= 1'b0;
         derrota_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         senha_a_q <= senha_a_d;
         senha_b_q <= senha_b_d;
         tent_a_q  <= tent_a_d;
         tent_b_q  <= tent_b_d;
         modo_b_q  <= modo_b_d;
         vitoria_q <= vitoria_d;
         derrota_q <= derrota_d;
      end
   end

`ifdef CONTROLE_JOGO_ULTIMA_DICA_EN
   logic [1:0] dica_q;

   // last hint: sampled in every evaluation cycle, forgotten on restart
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dica_q <= DICA_NULA;
      end else if (cnt_clr) begin
         dica_q <= DICA_NULA;
      end else if ((estado_q == AVALIA_A) || (estado_q == AVALIA_B)) begin
         dica_q <= comp;
      end else begin
         dica_q <= dica_q;
      end
   end

   assign ultima_dica = dica_q;
`else
   assign ultima_dica = DICA_NULA;
`endif

   assign senhaA     = senha_a_q;
   assign senhaB     = senha_b_q;
   assign tentativaA = tent_a_q;
   assign tentativaB = tent_b_q;
   assign modoB      = modo_b_q;
   assign vitoria    = vitoria_q;
   assign derrota    = derrota_q;
   assign fase       = estado_q;

endmodule

// File: tb/tb_controle_jogo.sv
// Self-checking bench: three controllers (budgets 8, 3, 2) against a game-rule reference model.
module tb_controle_jogo;

   localparam int N = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn;
   logic [3:0] sw;
   logic [1:0] comp_s [N];

   logic [3:0] sa_o [N];
   logic [2:0] sb_o [N];
   logic [3:0] ta_o [N];
   logic [2:0] tb_o [N];
   logic       mb_o [N];
   logic [3:0] nt_o [N];
   logic       vit_o [N];
   logic       der_o [N];
   logic [2:0] fase_o [N];
   logic [1:0] ud_o [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      controle_jogo #(.MAX_TENT((g == 0) ? 8 : ((g == 1) ? 3 : 2))) dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .sw_valor     (sw),
         .btn_confirma (btn),
         .comp         (comp_s[g]),
         .senhaA       (sa_o[g]),
         .senhaB       (sb_o[g]),
         .tentativaA   (ta_o[g]),
         .tentativaB   (tb_o[g]),
         .modoB        (mb_o[g]),
         .tentativas   (nt_o[g]),
         .vitoria      (vit_o[g]),
         .derrota      (der_o[g]),
         .fase         (fase_o[g]),
         .ultima_dica  (ud_o[g])
      );
   end

   always #5 clk = ~clk;

   // Reference model: game phase numbers follow the display codes
   int max_v [N] = '{8, 3, 2};
   int m_ph [N];
   int m_sa [N], m_sb [N], m_ga [N], m_gb [N];
   int m_nt [N], m_mb [N], m_ud [N];
   int n_pass = 0;
   int n_total = 0;

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_ph[k] = 0; m_sa[k] = 0; m_sb[k] = 0; m_ga[k] = 0; m_gb[k] = 0;
         m_nt[k] = 0; m_mb[k] = 0; m_ud[k] = 3;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < N; k++) begin
         int c;
         c = int'(comp_s[k]);
         case (m_ph[k])
            0: if (btn) begin m_sa[k] = int'(sw); m_ph[k] = 1; end
            1: if (btn) begin m_sb[k] = int'(sw) % 8; m_ph[k] = 2; end
            2: if (btn) begin
                  m_ga[k] = int'(sw);
                  m_nt[k] = (m_nt[k] + 1 > max_v[k]) ? max_v[k] : m_nt[k] + 1;
                  m_ph[k] = 3;
               end
            3: begin
                  m_ud[k] = c;
                  m_ph[k] = (c == 2) ? 4 : ((m_nt[k] == max_v[k]) ? 7 : 2);
               end
            4: if (btn) begin
                  m_gb[k] = int'(sw) % 8;
                  m_nt[k] = (m_nt[k] + 1 > max_v[k]) ? max_v[k] : m_nt[k] + 1;
                  m_ph[k] = 5;
               end
            5: begin
                  m_ud[k] = c;
                  m_ph[k] = (c == 2) ? 6 : ((m_nt[k] == max_v[k]) ? 7 : 4);
               end
            default: if (btn) begin
                  m_ph[k] = 0; m_sa[k] = 0; m_sb[k] = 0; m_ga[k] = 0; m_gb[k] = 0;
                  m_nt[k] = 0; m_mb[k] = 0; m_ud[k] = 3;
               end
         endcase
         if (m_ph[k] == 4 || m_ph[k] == 5) m_mb[k] = 1;
      end
   endtask

   // Plays the role of the hint block: compares the model's own secret and guess
   task automatic drive_comp();
      for (int k = 0; k < N; k++) begin
         int c, g, s;
         if (m_ph[k] == 3 || m_ph[k] == 5) begin
            g = (m_ph[k] == 3) ? m_ga[k] : m_gb[k];
            s = (m_ph[k] == 3) ? m_sa[k] : m_sb[k];
            if (g == s) c = 2;
            else if ($urandom_range(0, 7) == 0) c = 3;
            else c = (g < s) ? 0 : 1;
         end else begin
            c = int'($urandom_range(0, 3));
         end
         comp_s[k] = 2'(c);
      end
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_all();
      for (int k = 0; k < N; k++) begin
         int ud_exp;
`ifdef CONTROLE_JOGO_ULTIMA_DICA_EN
         ud_exp = m_ud[k];
`else
         ud_exp = 3;
`endif
         chk($sformatf("i%0d.fase", k),        4'(fase_o[k]), 4'(m_ph[k]));
         chk($sformatf("i%0d.tentativas", k),  nt_o[k],       4'(m_nt[k]));
         chk($sformatf("i%0d.senhaA", k),      sa_o[k],       4'(m_sa[k]));
         chk($sformatf("i%0d.senhaB", k),      4'(sb_o[k]),   4'(m_sb[k]));
         chk($sformatf("i%0d.tentativaA", k),  ta_o[k],       4'(m_ga[k]));
         chk($sformatf("i%0d.tentativaB", k),  4'(tb_o[k]),   4'(m_gb[k]));
         chk($sformatf("i%0d.modoB", k),       4'(mb_o[k]),   4'(m_mb[k]));
         chk($sformatf("i%0d.vitoria", k),     4'(vit_o[k]),  4'(m_ph[k] == 6));
         chk($sformatf("i%0d.derrota", k),     4'(der_o[k]),  4'(m_ph[k] == 7));
         chk($sformatf("i%0d.ultima_dica", k), 4'(ud_o[k]),   4'(ud_exp));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      else model_reset();
      #1;
      drive_comp();
      check_all();
   endtask

   task automatic confirm(input int v);
      sw  = 4'(v);
      btn = 1'b1;
      tick();
      btn = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      drive_comp();
      check_all();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      btn   = 1'b0;
      sw    = 4'd0;
      for (int k = 0; k < N; k++) comp_s[k] = 2'b00;
      model_reset();
      #2;
      check_all();
      tick();
      rst_n = 1'b1;
      tick();

      // A=9, B=5, guess 9 with confirm held across the evaluation, then 5: win
      confirm(9);
      confirm(5);
      sw = 4'd9; btn = 1'b1;
      tick();
      tick();
      btn = 1'b0;
      tick();
      confirm(5);
      tick();
      confirm(0);

      // A=3, wrong guess 7 goes back to guessing A
      do_reset();
      confirm(3);
      confirm(1);
      confirm(7);
      tick();

      // budget exhaustion on wrong guesses 0,1,4
      do_reset();
      confirm(2);
      confirm(0);
      confirm(0);
      confirm(1);
      confirm(4);
      tick();

      // hit on the last allowed guess beats exhaustion, then a wrong B guess loses
      do_reset();
      confirm(6);
      confirm(3);
      confirm(1);
      confirm(6);
      confirm(0);
      tick();

      // reset asserted in the middle of a phase-B evaluation
      do_reset();
      confirm(4);
      confirm(2);
      confirm(4);
      sw = 4'd2; btn = 1'b1;
      tick();
      btn = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      drive_comp();
      check_all();
      tick();
      rst_n = 1'b1;
      tick();

      // random play, biased toward correct guesses for instance 0
      for (int i = 0; i < 300; i++) begin
         int v;
         if ($urandom_range(0, 1) == 0)
            v = (m_ph[0] == 4) ? m_sb[0] : m_sa[0];
         else
            v = int'($urandom_range(0, 15));
         confirm(v);
         repeat ($urandom_range(0, 2)) tick();
         if ($urandom_range(0, 59) == 0) do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
